// File: rtl/jtopl_pkg.sv
// Shared definitions for the OPL CPU-port write sequencer.
//   - FSM state encoding
//   - request word layout {rd, reg[7:0], val[7:0]} (17 bits)
//   - chip post-write recovery defaults
package jtopl_pkg;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    ADR_SET  = 4'd1,
    ADR_STB  = 4'd2,
    ADR_WAIT = 4'd3,
    DAT_SET  = 4'd4,
    DAT_STB  = 4'd5,
    DAT_WAIT = 4'd6,
    RD_SET   = 4'd7,
    RD_STB   = 4'd8
  } state_t;

  localparam int REQ_W       = 17;
  localparam int REQ_RD      = 16;
  localparam int REQ_REG_LSB = 8;
  localparam int REQ_VAL_LSB = 0;

  // Recovery time the chip needs after an address / data write (cen cycles)
  localparam int OPL_ADDR_WAIT = 12;
  localparam int OPL_DATA_WAIT = 84;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/jtopl_cpu_wr_if.sv
// Host request / read-response bundle for jtopl_cpu_wr.
//   req_valid/req_ready : push handshake
//   req_rd/req_reg/req_val : request payload
//   rd_valid/rd_data    : status-read result (one-clk pulse)
interface jtopl_cpu_wr_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_rd;
  logic [7:0] req_reg;
  logic [7:0] req_val;
  logic       rd_valid;
  logic [7:0] rd_data;

  modport master (output req_valid, req_rd, req_reg, req_val,
                  input  req_ready, rd_valid, rd_data);
  modport slave  (input  req_valid, req_rd, req_reg, req_val,
                  output req_ready, rd_valid, rd_data);
endinterface

// File: rtl/jtopl_wr_fifo.sv
// Request FIFO. Pointers carry an extra wrap bit so full/empty need no
// separate counter. Read data is the combinational head entry.
//   clk, rst_n : clock, async active-low reset
//   push, din  : write port (caller guarantees !full || pop)
//   pop, dout  : read port (caller guarantees !empty)
//   full, empty: status
module jtopl_wr_fifo
  import jtopl_pkg::*;
#(
  parameter int DEPTH = 4
)(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [REQ_W-1:0] din,
  output logic [REQ_W-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [REQ_W-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // When full, push and pop hit the same slot; the pop reads the old
  // entry through dout before this edge overwrites it.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/jtopl_cpu_wr.sv
// Bus master for the OPL CPU port. Queues register writes and status reads,
// then plays each write as address strobe / address recovery / data strobe /
// data recovery, and each read as a cs_n-only strobe with a sample of dout.
//   clk, rst_n, cen : clock, async active-low reset, chip clock enable
//   bus             : request push + read-result pulse
//   busy            : queue non-empty or sequence in progress
//   opl_*           : registered chip CPU port, opl_dout = chip status
module jtopl_cpu_wr
  import jtopl_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int STB_LEN   = 2,
  parameter int ADDR_WAIT = OPL_ADDR_WAIT,
  parameter int DATA_WAIT = OPL_DATA_WAIT
)(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cen,
  jtopl_cpu_wr_if.slave bus,
  output logic         busy,
  output logic         opl_addr,
  output logic [7:0]   opl_din,
  output logic         opl_cs_n,
  output logic         opl_wr_n,
  input  logic [7:0]   opl_dout
);
  localparam int AW_EFF = (ADDR_WAIT < 1) ? 1 : ADDR_WAIT;
  localparam int DW_EFF = (DATA_WAIT < 1) ? 1 : DATA_WAIT;
  localparam int CW     = $clog2(max3(STB_LEN, ADDR_WAIT, DATA_WAIT) + 1);

  // Counters load length-1 on state entry and leave the state at zero
  localparam logic [CW-1:0] STB_LD = CW'(STB_LEN - 1);
  localparam logic [CW-1:0] ADR_LD = CW'(AW_EFF - 1);
  localparam logic [CW-1:0] DAT_LD = CW'(DW_EFF - 1);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [7:0]       hold_val;
  logic             rd_pend;
  logic [7:0]       rd_smp;
  logic             rd_valid_r;
  logic [7:0]       rd_data_r;

  logic             push, pop, full, empty;
  logic [REQ_W-1:0] fifo_din, fifo_dout;

  assign pop           = cen && (state == IDLE) && !empty;
  assign bus.req_ready = !full || pop;
  assign push          = bus.req_valid && bus.req_ready;
  assign fifo_din      = {bus.req_rd, bus.req_reg, bus.req_val};
  assign busy          = !empty || (state != IDLE);
  assign bus.rd_valid  = rd_valid_r;
  assign bus.rd_data   = rd_data_r;

  jtopl_wr_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (push),
    .pop  (pop),
    .din  (fifo_din),
    .dout (fifo_dout),
    .full (full),
    .empty(empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      hold_val   <= '0;
      rd_pend    <= 1'b0;
      rd_smp     <= '0;
      rd_valid_r <= 1'b0;
      rd_data_r  <= '0;
      opl_addr   <= 1'b0;
      opl_din    <= '0;
      opl_cs_n   <= 1'b1;
      opl_wr_n   <= 1'b1;
    end else begin
      // Result presentation runs on clk, not cen, so the pulse is one clk wide
      rd_valid_r <= rd_pend;
      if (rd_pend) rd_data_r <= rd_smp;
      rd_pend <= 1'b0;
      if (cen) begin
        case (state)
          IDLE: if (!empty) begin
            hold_val <= fifo_dout[REQ_VAL_LSB +: 8];
            opl_addr <= 1'b0;
            opl_cs_n <= 1'b1;
            opl_wr_n <= 1'b1;
            if (fifo_dout[REQ_RD]) begin
              state <= RD_SET;
            end else begin
              opl_din <= fifo_dout[REQ_REG_LSB +: 8];
              state   <= ADR_SET;
            end
          end
          ADR_SET: begin
            opl_cs_n <= 1'b0;
            opl_wr_n <= 1'b0;
            cnt      <= STB_LD;
            state    <= ADR_STB;
          end
          ADR_STB: if (cnt == '0) begin
            opl_cs_n <= 1'b1;
            opl_wr_n <= 1'b1;
            cnt      <= ADR_LD;
            state    <= ADR_WAIT;
          end else cnt <= cnt - CW'(1);
          ADR_WAIT: if (cnt == '0) begin
            opl_addr <= 1'b1;
            opl_din  <= hold_val;
            state    <= DAT_SET;
          end else cnt <= cnt - CW'(1);
          DAT_SET: begin
            opl_cs_n <= 1'b0;
            opl_wr_n <= 1'b0;
            cnt      <= STB_LD;
            state    <= DAT_STB;
          end
          DAT_STB: if (cnt == '0) begin
            opl_cs_n <= 1'b1;
            opl_wr_n <= 1'b1;
            cnt      <= DAT_LD;
            state    <= DAT_WAIT;
          end else cnt <= cnt - CW'(1);
          DAT_WAIT: if (cnt == '0) state <= IDLE;
                    else cnt <= cnt - CW'(1);
          RD_SET: begin
            opl_cs_n <= 1'b0;
            cnt      <= STB_LD;
            state    <= RD_STB;
          end
          RD_STB: if (cnt == '0) begin
            opl_cs_n <= 1'b1;
            rd_smp   <= opl_dout;
            rd_pend  <= 1'b1;
            state    <= IDLE;
          end else cnt <= cnt - CW'(1);
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_jtopl_cpu_wr.sv
module tb_jtopl_cpu_wr;
  logic clk = 1'b0, rst_n = 1'b0, cen = 1'b1, cen_q = 1'b1;
  int   cen_div = 1, cen_cnt = 0;
  int   n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  // cen is high one edge in every cen_div edges
  always @(posedge clk) begin
    cen_cnt <= (cen_cnt + 1 >= cen_div) ? 0 : cen_cnt + 1;
    cen     <= (cen_cnt + 1 >= cen_div);
    cen_q   <= cen;
  end

  // main DUT, default timing
  jtopl_cpu_wr_if bus ();
  logic       busy, opl_addr, cs_n, wr_n;
  logic [7:0] opl_din, opl_dout;
  jtopl_cpu_wr u_dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .bus(bus), .busy(busy),
    .opl_addr(opl_addr), .opl_din(opl_din), .opl_cs_n(cs_n),
    .opl_wr_n(wr_n), .opl_dout(opl_dout)
  );

  // minimal-timing DUT
  jtopl_cpu_wr_if bus2 ();
  logic       busy2, e_addr, e_cs_n, e_wr_n;
  logic [7:0] e_din;
  jtopl_cpu_wr #(.DEPTH(2), .STB_LEN(1), .ADDR_WAIT(0), .DATA_WAIT(0)) u_edge (
    .clk(clk), .rst_n(rst_n), .cen(cen), .bus(bus2), .busy(busy2),
    .opl_addr(e_addr), .opl_din(e_din), .opl_cs_n(e_cs_n),
    .opl_wr_n(e_wr_n), .opl_dout(8'h00)
  );

  // chip model + scoreboard
  logic [7:0]  chip_reg [256];
  logic [7:0]  chip_idx = 8'h00;
  logic        tmr_flag = 1'b0, prev_cs = 1'b1;
  logic [15:0] exp_wr_q [$];
  logic [7:0]  exp_rd_q [$];
  logic [15:0] e_wr;
  logic [7:0]  e_rd;

  assign opl_dout = tmr_flag ? 8'hC6 : 8'h06;

  always @(negedge clk) begin
    n_cmp++;
    if (!wr_n && cs_n) begin
      n_err++;
      $display("FAIL wr_without_cs: wr_n=%b cs_n=%b, want wr_n=1 while cs_n=1", wr_n, cs_n);
    end
    if (!cs_n && !wr_n && prev_cs) begin
      if (!opl_addr) chip_idx = opl_din;
      else begin
        chip_reg[chip_idx] = opl_din;
        if (chip_idx == 8'h04) begin
          if (opl_din[7]) tmr_flag = 1'b0;
          else if (opl_din[0]) tmr_flag = 1'b1;
        end
        n_cmp++;
        if (exp_wr_q.size() == 0) begin
          n_err++;
          $display("FAIL chip_write: got %h=%h, want no write", chip_idx, opl_din);
        end else begin
          e_wr = exp_wr_q.pop_front();
          if ({chip_idx, opl_din} !== e_wr) begin
            n_err++;
            $display("FAIL chip_write: got %h=%h want %h=%h", chip_idx, opl_din, e_wr[15:8], e_wr[7:0]);
          end
        end
      end
    end
    prev_cs = cs_n;
    if (bus.rd_valid) begin
      n_cmp++;
      if (exp_rd_q.size() == 0) begin
        n_err++;
        $display("FAIL rd_result: got %h, want no rd_valid", bus.rd_data);
      end else begin
        e_rd = exp_rd_q.pop_front();
        if (bus.rd_data !== e_rd) begin
          n_err++;
          $display("FAIL rd_result: got %h want %h", bus.rd_data, e_rd);
        end
      end
    end
  end

  task automatic push_req(input logic rd, input logic [7:0] rg, input logic [7:0] vl);
    int w;
    w = 0;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_rd = rd; bus.req_reg = rg; bus.req_val = vl;
    while (!bus.req_ready && w < 2000) begin @(negedge clk); w++; end
    if (w >= 2000) begin
      n_cmp++; n_err++;
      $display("FAIL push_timeout: req_ready=0 for %0d cycles, want 1", w);
    end
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    while (busy && w < 5000) begin @(negedge clk); w++; end
    if (busy) begin
      n_cmp++; n_err++;
      $display("FAIL idle_timeout: busy=%b want 0", busy);
    end
  endtask

  // t=0 is the first negedge after the push edge (the pop cycle when cen=1)
  task automatic measure_write(output int t_adr, output int n_adr, output int t_dat,
                               output int n_dat, output int t_rise, output int t_busy,
                               output int n_bad);
    logic [10:0] snap;
    t_adr = -1; n_adr = 0; t_dat = -1; n_dat = 0; t_rise = -1; t_busy = -1; n_bad = 0;
    snap = '0;
    for (int t = 0; t < 5000; t++) begin
      @(negedge clk);
      if (t > 0 && !cen_q && {opl_addr, opl_din, cs_n, wr_n} !== snap) n_bad++;
      snap = {opl_addr, opl_din, cs_n, wr_n};
      if (!cs_n && !opl_addr) begin n_adr++; if (t_adr < 0) t_adr = t; end
      if (!cs_n && opl_addr)  begin n_dat++; if (t_dat < 0) t_dat = t; end
      if (cs_n && t_dat >= 0 && t_rise < 0) t_rise = t;
      if (!busy) begin t_busy = t; break; end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({cs_n, wr_n, opl_addr, opl_din} !== 11'b11_0_00000000) begin
      n_err++;
      $display("FAIL reset_chip_port: got cs=%b wr=%b a=%b din=%h want 1 1 0 00", cs_n, wr_n, opl_addr, opl_din);
    end
    n_cmp++;
    if ({bus.rd_valid, bus.rd_data, bus.req_ready, busy} !== 11'b0_00000000_1_0) begin
      n_err++;
      $display("FAIL reset_host: got rdv=%b rdd=%h rdy=%b busy=%b want 0 00 1 0",
               bus.rd_valid, bus.rd_data, bus.req_ready, busy);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single_write();
    int ta, na, td, nd, tr, tb, nb;
    exp_wr_q.push_back({8'h20, 8'h01});
    push_req(1'b0, 8'h20, 8'h01);
    measure_write(ta, na, td, nd, tr, tb, nb);
    n_cmp++; if (ta !== 2)   begin n_err++; $display("FAIL wr_adr_fall: got %0d want 2", ta); end
    n_cmp++; if (na !== 2)   begin n_err++; $display("FAIL wr_adr_len: got %0d want 2", na); end
    n_cmp++; if (td !== 17)  begin n_err++; $display("FAIL wr_dat_fall: got %0d want 17", td); end
    n_cmp++; if (nd !== 2)   begin n_err++; $display("FAIL wr_dat_len: got %0d want 2", nd); end
    n_cmp++; if (tb !== 103) begin n_err++; $display("FAIL wr_busy_fall: got %0d want 103", tb); end
    n_cmp++; if (chip_reg[8'h20] !== 8'h01) begin
      n_err++; $display("FAIL wr_chip_reg20: got %h want 01", chip_reg[8'h20]);
    end
  endtask

  task automatic test_status_read();
    int tv;
    exp_wr_q.push_back({8'h02, 8'hFF}); push_req(1'b0, 8'h02, 8'hFF);
    exp_wr_q.push_back({8'h04, 8'h01}); push_req(1'b0, 8'h04, 8'h01);
    wait_idle();
    exp_rd_q.push_back(8'hC6);
    push_req(1'b1, 8'h00, 8'h00);
    tv = -1;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (bus.rd_valid) begin tv = t; break; end
    end
    n_cmp++; if (tv !== 5) begin n_err++; $display("FAIL rd_latency: got %0d want 5", tv); end
    @(negedge clk);
    n_cmp++;
    if ({bus.rd_valid, bus.rd_data} !== {1'b0, 8'hC6}) begin
      n_err++; $display("FAIL rd_hold: got v=%b d=%h want 0 c6", bus.rd_valid, bus.rd_data);
    end
    exp_wr_q.push_back({8'h04, 8'h80}); push_req(1'b0, 8'h04, 8'h80);
    exp_rd_q.push_back(8'h06);          push_req(1'b1, 8'h00, 8'h00);
    wait_idle();
    repeat (3) @(negedge clk);
    n_cmp++;
    if (exp_rd_q.size() != 0 || bus.rd_data !== 8'h06) begin
      n_err++; $display("FAIL rd_noflags: got d=%h left=%0d want 06 0", bus.rd_data, exp_rd_q.size());
    end
  endtask

  task automatic test_back_to_back();
    int acc, e, e6, acc20;
    logic took;
    acc = 0; e = 0; e6 = -1; acc20 = -1;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_rd = 1'b0; bus.req_reg = 8'h40; bus.req_val = 8'hA0;
    while (acc < 7 && e < 1000) begin
      took = bus.req_ready;
      if (took) exp_wr_q.push_back({8'h40 + 8'(acc), 8'hA0 + 8'(acc)});
      @(posedge clk); #1;
      if (took) begin
        acc++;
        if (acc == 6) e6 = e;
        bus.req_reg = 8'h40 + 8'(acc); bus.req_val = 8'hA0 + 8'(acc);
      end
      if (e == 20) acc20 = acc;
      e++;
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    n_cmp++; if (acc20 !== 5) begin n_err++; $display("FAIL bp_accepted: got %0d want 5", acc20); end
    n_cmp++; if (e6 !== 104)  begin n_err++; $display("FAIL bp_sixth_edge: got %0d want 104", e6); end
    wait_idle();
    n_cmp++; if (exp_wr_q.size() != 0) begin
      n_err++; $display("FAIL bp_order: got %0d pending want 0", exp_wr_q.size());
    end
  endtask

  task automatic test_cen_gating();
    int ta, na, td, nd, tr, tb, nb;
    cen_div = 6;
    repeat (8) @(negedge clk);
    exp_wr_q.push_back({8'h21, 8'h5A});
    push_req(1'b0, 8'h21, 8'h5A);
    measure_write(ta, na, td, nd, tr, tb, nb);
    n_cmp++; if (na !== 12)      begin n_err++; $display("FAIL cen_adr_len: got %0d want 12", na); end
    n_cmp++; if (nd !== 12)      begin n_err++; $display("FAIL cen_dat_len: got %0d want 12", nd); end
    n_cmp++; if (td - ta !== 90) begin n_err++; $display("FAIL cen_adr_to_dat: got %0d want 90", td - ta); end
    n_cmp++; if (tb - tr !== 504) begin n_err++; $display("FAIL cen_dat_wait: got %0d want 504", tb - tr); end
    n_cmp++; if (nb !== 0)       begin n_err++; $display("FAIL cen_hold: got %0d changes want 0", nb); end
    cen_div = 1;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_param_edge();
    int ta, na, td, nd, tb;
    logic [7:0] da, dd;
    ta = -1; na = 0; td = -1; nd = 0; tb = -1; da = '0; dd = '0;
    @(negedge clk);
    bus2.req_valid = 1'b1; bus2.req_rd = 1'b0; bus2.req_reg = 8'h33; bus2.req_val = 8'h77;
    @(posedge clk);
    #1 bus2.req_valid = 1'b0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (!e_cs_n && !e_wr_n && !e_addr) begin na++; if (ta < 0) begin ta = t; da = e_din; end end
      if (!e_cs_n && !e_wr_n && e_addr)  begin nd++; if (td < 0) begin td = t; dd = e_din; end end
      if (!busy2) begin tb = t; break; end
    end
    n_cmp++; if (tb !== 7) begin n_err++; $display("FAIL edge_total: got %0d want 7", tb); end
    n_cmp++; if ({ta, na} !== {32'd2, 32'd1}) begin
      n_err++; $display("FAIL edge_adr_stb: got t=%0d n=%0d want 2 1", ta, na);
    end
    n_cmp++; if ({td, nd} !== {32'd5, 32'd1}) begin
      n_err++; $display("FAIL edge_dat_stb: got t=%0d n=%0d want 5 1", td, nd);
    end
    n_cmp++; if ({da, dd} !== 16'h3377) begin
      n_err++; $display("FAIL edge_din: got %h/%h want 33/77", da, dd);
    end
  endtask

  task automatic test_reset_mid_op();
    repeat (4) push_req(1'b0, 8'h60, 8'h11);
    n_cmp++; if (cs_n !== 1'b0) begin n_err++; $display("FAIL rst_pre_strobe: cs_n=%b want 0", cs_n); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({cs_n, wr_n, busy, bus.req_ready} !== 4'b1101) begin
      n_err++; $display("FAIL rst_async: got cs=%b wr=%b busy=%b rdy=%b want 1 1 0 1",
                        cs_n, wr_n, busy, bus.req_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (400) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_dropped: busy=%b want 0", busy); end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.req_valid = 1'b0; bus.req_rd = 1'b0; bus.req_reg = '0; bus.req_val = '0;
    bus2.req_valid = 1'b0; bus2.req_rd = 1'b0; bus2.req_reg = '0; bus2.req_val = '0;
    test_reset();
    test_single_write();
    test_status_read();
    test_back_to_back();
    test_cen_gating();
    test_param_edge();
    test_reset_mid_op();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
